register_file: RTL and testbench
================================

// Module: register_file
//
// PURPOSE
//   Architectural register file directly downstream of the 4:1 writeback
//   result multiplexer in the single-cycle datapath. Holds R0..R14 as
//   clocked state and returns the PC+8 input for any read of R15.
//   Provides three combinational read ports: Rn, Rm, and Rd/Rs for stores
//   and register-specified shifts.
//   Provides one general write port, fed by the result mux, and one
//   dedicated link write port that loads R14 on BL.
//
// PARAMETERS
//   WIDTH        32   data width of every register and data port
//   RESET_VALUE  0    value loaded into R0..R14 on reset
//
// PORTS
//   clk            in   1      rising-edge clock
//   reset_n        in   1      asynchronous, active-low reset
//   write_enable   in   1      commit write_data to write_addr at next rising edge
//   write_addr     in   4      destination register index
//   write_data     in   WIDTH  value from the writeback result mux
//   link_enable    in   1      commit link_data to R14 at next rising edge
//   link_data      in   WIDTH  return address (PC+4)
//   r15_value      in   WIDTH  PC+8; returned for any read of index 15
//   read_addr1     in   4      read port 1 index (Rn)
//   read_addr2     in   4      read port 2 index (Rm)
//   read_addr3     in   4      read port 3 index (Rd/Rs)
//   read_data1     out  WIDTH  contents of read_addr1
//   read_data2     out  WIDTH  contents of read_addr2
//   read_data3     out  WIDTH  contents of read_addr3
//   debug_addr     in   4      observation index
//   debug_data     out  WIDTH  contents of debug_addr (same rules as read ports)
//
// BEHAVIOUR
// - Storage: 15 registers R0..R14, each WIDTH bits. R15 has no storage.
// - Reset: while reset_n=0, R0..R14 = RESET_VALUE immediately, without
//   waiting for a clock edge. This is reset-dominant: writes presented
//   during reset are lost.
// - On reset deassertion, normal writes resume at the first rising edge
//   after reset_n=1.
// - Reads are purely combinational, with zero-cycle latency:
//   * index 0..14 returns the stored value;
//   * index 15 returns r15_value.
//   * The same rules apply to all four output ports.
// - Write timing: at a rising edge with write_enable=1 and write_addr in
//   0..14, the register takes write_data. The new value is visible on
//   read ports only after that edge.
// - There is no write-to-read bypass. A same-cycle read of the address
//   being written returns the OLD value. Bypass would close a
//   combinational loop through the ALU and the result mux.
// - A write to index 15 is ignored (no state change). PC update is owned
//   by the PC stage.
// - Link: at a rising edge with link_enable=1, R14 takes link_data.
// - Simultaneous events:
//   * link_enable=1 and write_enable=1 with write_addr=14: link_data
//     wins and write_data is dropped.
//   * link_enable=1 and write_enable=1 with write_addr!=14: both writes
//     commit in the same edge.
// - Enables low: all state holds.
// - All ports are WIDTH bits; there is no sign or zero extension inside
//   this block.
// - X-safety: an X on any enable must not corrupt a register while
//   reset_n=0.
//
// TESTING
// 1. Reset: write R3=0xDEADBEEF, then pulse reset_n low mid-cycle ->
//    read_data1 for addr 3 reads 0x00000000 before the next clk edge.
// 2. Write/read latency: write_enable=1, addr 5, data 0x12345678 ->
//    read_data2 for addr 5 shows the old value in the same cycle and
//    0x12345678 after the edge.
// 3. R15: write_enable=1, addr 15, data 0xFFFFFFFF, with r15_value=0x00000108
//    -> read_data3 for addr 15 = 0x00000108, and no register changes.
// 4. Link collision: link_enable=1 with link_data=0x00000204, and
//    write_enable=1 with addr 14, data 0xAAAA0000 -> R14 = 0x00000204.
// 5. Dual commit: link_enable=1 with 0x40, write addr 2 with 0x55 ->
//    R14=0x40 and R2=0x55 after a single edge; all other registers unchanged.
// 6. Sweep: write i*0x11 to each of R0..R14, then read each on all three
//    ports and debug_data -> every port matches, including a read of
//    addr 15 returning r15_value.

Source files
------------

// File: rtl/register_file_if.sv
// Register file access bundle.
// Groups the write port, the link port, the PC+8 value, the three read ports
// and the debug observation port of the architectural register file.
//   master : datapath side, drives indices/enables/data, receives read data
//   slave  : register file side, receives indices/enables/data, drives read data
interface register_file_if #(
  parameter int WIDTH = 32
);
  logic             write_enable;
  logic [3:0]       write_addr;
  logic [WIDTH-1:0] write_data;
  logic             link_enable;
  logic [WIDTH-1:0] link_data;
  logic [WIDTH-1:0] r15_value;
  logic [3:0]       read_addr1;
  logic [3:0]       read_addr2;
  logic [3:0]       read_addr3;
  logic [WIDTH-1:0] read_data1;
  logic [WIDTH-1:0] read_data2;
  logic [WIDTH-1:0] read_data3;
  logic [3:0]       debug_addr;
  logic [WIDTH-1:0] debug_data;

  modport master (
    output write_enable, write_addr, write_data,
    output link_enable, link_data, r15_value,
    output read_addr1, read_addr2, read_addr3, debug_addr,
    input  read_data1, read_data2, read_data3, debug_data
  );

  modport slave (
    input  write_enable, write_addr, write_data,
    input  link_enable, link_data, r15_value,
    input  read_addr1, read_addr2, read_addr3, debug_addr,
    output read_data1, read_data2, read_data3, debug_data
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file for the single-cycle datapath.
// R0..R14 are clocked state; any read of index 15 returns the PC+8 value
// supplied on rf.r15_value. Three combinational read ports plus a debug port,
// one general write port and one dedicated link port that loads R14.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, loads RESET_VALUE into R0..R14
//   rf      : register_file_if slave modport (write, link, read, debug)
module register_file #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  register_file_if.slave   rf
);

  localparam int NREGS = 15;
  localparam int LR    = 14;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] view_s [16];

  // Next-state for each stored register; the link port takes priority on R14.
  // A write to index 15 matches no stored register and is therefore dropped.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if ((i == LR) && rf.link_enable) begin
        regs_d[i] = rf.link_data;
      end else if (rf.write_enable && (rf.write_addr == 4'(i))) begin
        regs_d[i] = rf.write_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Storage; reset dominates so enables (even unknown ones) cannot disturb state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read view over all 16 indices: stored state plus PC+8 at index 15.
  // Reads come from regs_q only, so there is no write-to-read bypass.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      view_s[i] = regs_q[i];
    end
    view_s[15] = rf.r15_value;
  end

  assign rf.read_data1 = view_s[rf.read_addr1];
  assign rf.read_data2 = view_s[rf.read_addr2];
  assign rf.read_data3 = view_s[rf.read_addr3];
  assign rf.debug_data = view_s[rf.debug_addr];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  localparam int WIDTH = 32;

  typedef struct {
    string       tag;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] d3;
    logic [31:0] dd;
  } exp_t;

  logic clk;
  logic reset_n;
  register_file_if #(.WIDTH(WIDTH)) bus ();

  register_file #(.WIDTH(WIDTH), .RESET_VALUE(32'h0000_0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rf      (bus)
  );

  // Reference state: plain array of the 15 architectural registers.
  logic [31:0] mdl [15];
  exp_t        exp_q [$];
  event        sample_ev;
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic [3:0] a);
    if (a == 4'd15) return bus.r15_value;
    return mdl[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: whenever a read is presented, pop the expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".rd1"}, bus.read_data1, e.d1);
        chk({e.tag, ".rd2"}, bus.read_data2, e.d2);
        chk({e.tag, ".rd3"}, bus.read_data3, e.d3);
        chk({e.tag, ".dbg"}, bus.debug_data, e.dd);
      end
    end
  end

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic le, input logic [31:0] ld, input logic [31:0] r15);
    bus.write_enable = we;
    bus.write_addr   = wa;
    bus.write_data   = wd;
    bus.link_enable  = le;
    bus.link_data    = ld;
    bus.r15_value    = r15;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 32'h0, bus.r15_value);
  endtask

  task automatic probe(input string tag, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] a3, input logic [3:0] ad);
    exp_t e;
    bus.read_addr1 = a1;
    bus.read_addr2 = a2;
    bus.read_addr3 = a3;
    bus.debug_addr = ad;
    #1;
    e.tag = tag;
    e.d1  = model_rd(a1);
    e.d2  = model_rd(a2);
    e.d3  = model_rd(a3);
    e.dd  = model_rd(ad);
    exp_q.push_back(e);
    ->sample_ev;
    #2;
  endtask

  // One rising edge: apply the architectural update rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) mdl[i] = 32'h0;
    end else begin
      if (bus.write_enable && bus.write_addr != 4'd15) mdl[bus.write_addr] = bus.write_data;
      if (bus.link_enable) mdl[14] = bus.link_data;
    end
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    idle();
    for (int a = 0; a < 16; a++) begin
      probe(tag, 4'(a), 4'((a + 5) % 16), 4'((a + 9) % 16), 4'((a + 13) % 16));
      tick();
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 15; i++) mdl[i] = 32'h0;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 32'h0000_0108);
    bus.read_addr1 = 4'd0;
    bus.read_addr2 = 4'd0;
    bus.read_addr3 = 4'd0;
    bus.debug_addr = 4'd0;
    @(negedge clk);

    // Reset state, with a write presented during reset that must be lost
    drive(1'b1, 4'd7, 32'h7777_7777, 1'b1, 32'h1414_1414, 32'h0000_0108);
    probe("rst_state", 4'd0, 4'd7, 4'd14, 4'd15);
    tick();
    probe("rst_dominant", 4'd7, 4'd14, 4'd3, 4'd15);
    idle();
    reset_n = 1'b1;
    tick();

    // Asynchronous reset mid-cycle
    drive(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0000_0108);
    tick();
    idle();
    probe("pre_async", 4'd3, 4'd0, 4'd15, 4'd3);
    reset_n = 1'b0;
    for (int i = 0; i < 15; i++) mdl[i] = 32'h0;
    probe("async_rst", 4'd3, 4'd3, 4'd3, 4'd3);
    tick();
    reset_n = 1'b1;

    // Write/read latency: old value same cycle, new after edge
    drive(1'b1, 4'd5, 32'h1111_0005, 1'b0, 32'h0, 32'h0000_0108);
    tick();
    drive(1'b1, 4'd5, 32'h1234_5678, 1'b0, 32'h0, 32'h0000_0108);
    probe("lat_old", 4'd1, 4'd5, 4'd5, 4'd5);
    tick();
    idle();
    probe("lat_new", 4'd1, 4'd5, 4'd5, 4'd5);
    tick();

    // Write to R15 ignored
    drive(1'b1, 4'd15, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0000_0108);
    probe("r15_read", 4'd15, 4'd5, 4'd15, 4'd15);
    tick();
    check_all("r15_nochg");

    // Link collision with general write to R14
    drive(1'b1, 4'd14, 32'hAAAA_0000, 1'b1, 32'h0000_0204, 32'h0000_0108);
    tick();
    idle();
    probe("link_win", 4'd14, 4'd14, 4'd14, 4'd14);
    tick();

    // Dual commit in a single edge
    drive(1'b1, 4'd2, 32'h0000_0055, 1'b1, 32'h0000_0040, 32'h0000_0108);
    tick();
    check_all("dual");

    // Sweep i*0x11 into R0..R14, read on every port
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 4'(i), 32'(i * 32'h11), 1'b0, 32'h0, 32'h0000_0108);
      tick();
    end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 32'h0000_0C08);
    check_all("sweep");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 3) == 0), $urandom, $urandom);
      probe("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
    end
    check_all("final");

    for (int k = 0; k < 100 && exp_q.size() > 0; k++) #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
